// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the fetch stage: 32-bit word type, fetch FSM state
//   encoding and the PC increment.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/ifid_latch.sv
// ifid_latch
//   Instruction / PC+4 / valid register with clear, load and hold.
//   Clear has priority over load; neither asserted holds the contents.
//   Used both for the IF/ID pipeline register and for the stall buffer.
// Ports
//   clk, rst        clock, asynchronous active-high reset (clears contents)
//   clear           zero instr/npc/valid next edge
//   load            capture d_instr/d_npc/d_valid next edge
//   d_instr/d_npc/d_valid   data to capture
//   instr/npc/valid         registered contents
module ifid_latch
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  load,
   input  word_t d_instr,
   input  word_t d_npc,
   input  logic  d_valid,
   output word_t instr,
   output word_t npc,
   output logic  valid
);

   word_t instr_q, instr_d;
   word_t npc_q,   npc_d;
   logic  valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
      if (clear) begin
         instr_d = '0;
         npc_d   = '0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = d_instr;
         npc_d   = d_npc;
         valid_d = d_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign npc   = npc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage with IF/ID register. Owns the PC, requests words
//   over iREN/ihit, buffers a word returned while decode is stalled, and
//   handles redirect, flush and HALT freeze.
// Optional feature: define FETCH_PERF_EN to add fetch_count / stall_count
//   saturating performance counters.
// Ports
//   CLK, RST                clock, asynchronous active-high reset
//   ihit, imemload          memory returns a word this cycle
//   iREN, imemaddr          read request and word-aligned fetch address
//   stall                   decode cannot accept, hold IF/ID
//   flush                   squash IF/ID contents
//   redirect, redirect_pc   load new PC (low two bits ignored)
//   halt                    freeze fetch until reset
//   instr_out, npc_out, valid_out   IF/ID contents
//   halted                  fetch frozen
//   fetch_count, stall_count        (FETCH_PERF_EN only)
//
// state  | meaning
// FETCH  | requesting pc; returned word goes to IF/ID, or to buffer if stalled
// HOLD   | word buffered during stall; no request until buffer drains
// HALTED | frozen by HALT; IF/ID invalid; only reset exits
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] instr_out,
   output logic [31:0] npc_out,
   output logic        valid_out,
   output logic        halted
`ifdef FETCH_PERF_EN
  ,output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pc_plus4;

   logic  ifid_load, ifid_clear, ifid_valid_d;
   word_t ifid_instr_d, ifid_npc_d;
   logic  buf_load, buf_clear;
   word_t buf_instr, buf_npc;
   logic  buf_valid;

   assign pc_plus4 = pc_q + PC_STEP;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_load    = 1'b0;
      ifid_clear   = 1'b0;
      ifid_instr_d = imemload;
      ifid_npc_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      if (state_q == HALTED) begin
         ifid_clear = 1'b1;
         buf_clear  = 1'b1;
      end else if (halt) begin
         state_d    = HALTED;
         ifid_clear = 1'b1;
         buf_clear  = 1'b1;
      end else if (redirect || flush) begin
         // Any buffered or same-cycle word belongs to the squashed path.
         state_d   = FETCH;
         buf_clear = 1'b1;
         if (redirect)
            pc_d = redirect_pc & ~word_t'(3);
         if (flush || !stall)
            ifid_clear = 1'b1;
      end else if (stall) begin
         if (state_q == FETCH && ihit) begin
            buf_load = 1'b1;
            pc_d     = pc_plus4;
            state_d  = HOLD;
         end
      end else begin
         case (state_q)
            FETCH: begin
               ifid_load = 1'b1;
               if (ihit) begin
                  pc_d = pc_plus4;
               end else begin
                  // Bubble: keep npc, drop instruction and valid.
                  ifid_instr_d = '0;
                  ifid_npc_d   = npc_out;
                  ifid_valid_d = 1'b0;
               end
            end
            HOLD: begin
               ifid_load    = 1'b1;
               ifid_instr_d = buf_instr;
               ifid_npc_d   = buf_npc;
               ifid_valid_d = buf_valid;
               buf_clear    = 1'b1;
               state_d      = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifid_latch u_ifid (
      .clk     (CLK),
      .rst     (RST),
      .clear   (ifid_clear),
      .load    (ifid_load),
      .d_instr (ifid_instr_d),
      .d_npc   (ifid_npc_d),
      .d_valid (ifid_valid_d),
      .instr   (instr_out),
      .npc     (npc_out),
      .valid   (valid_out)
   );

   ifid_latch u_hold_buf (
      .clk     (CLK),
      .rst     (RST),
      .clear   (buf_clear),
      .load    (buf_load),
      .d_instr (imemload),
      .d_npc   (pc_plus4),
      .d_valid (1'b1),
      .instr   (buf_instr),
      .npc     (buf_npc),
      .valid   (buf_valid)
   );

   // Request depends only on state and reset, never on ihit.
   assign iREN     = (state_q == FETCH) && !RST;
   assign imemaddr = {pc_q[31:2], 2'b00};
   assign halted   = (state_q == HALTED);

`ifdef FETCH_PERF_EN
   word_t fetch_count_q, fetch_count_d;
   word_t stall_count_q, stall_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (ifid_load && ifid_valid_d && !ifid_clear && fetch_count_q != '1)
         fetch_count_d = fetch_count_q + 32'd1;
      if (stall && state_q != HALTED && stall_count_q != '1)
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall, flush, redirect, halt;
   logic [31:0] redirect_pc;

   logic        iREN, valid_out, halted;
   logic [31:0] imemaddr, instr_out, npc_out;
   logic        w_iREN, w_valid_out, w_halted;
   logic [31:0] w_imemaddr, w_instr_out, w_npc_out;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
      .iREN(iREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out),
      .halted(halted)
`ifdef FETCH_PERF_EN
     ,.fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
      .iREN(w_iREN), .imemaddr(w_imemaddr), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .instr_out(w_instr_out), .npc_out(w_npc_out), .valid_out(w_valid_out),
      .halted(w_halted)
`ifdef FETCH_PERF_EN
     ,.fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
      flush = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
      #2;
      chk("rst_iren",     32'(iREN), 32'd0);
      chk("rst_valid",    32'(valid_out), 32'd0);
      chk("rst_instr",    instr_out, 32'h0);
      chk("rst_npc",      npc_out, 32'h0);
      chk("rst_halted",   32'(halted), 32'd0);
      chk("rst_addr",     imemaddr, 32'h0);
      chk("wrap_rst_addr", w_imemaddr, 32'hFFFF_FFFC);

      tick();
      RST = 1'b0;
      ihit = 1'b1; imemload = 32'h2001_0005;
      #1;
      chk("run_iren", 32'(iREN), 32'd1);
      chk("addr0",    imemaddr, 32'h0);

      tick();
      chk("first_instr", instr_out, 32'h2001_0005);
      chk("first_npc",   npc_out, 32'h4);
      chk("first_valid", 32'(valid_out), 32'd1);
      chk("addr4",       imemaddr, 32'h4);
      chk("wrap_npc",    w_npc_out, 32'h0);
      chk("wrap_valid",  32'(w_valid_out), 32'd1);
      chk("wrap_addr",   w_imemaddr, 32'h0);

      tick();
      chk("addr8", imemaddr, 32'h8);
      chk("npc8",  npc_out, 32'h8);

      // stall while word returns at pc=8
      stall = 1'b1; imemload = 32'hAC22_0000;
      tick();
      chk("hold_iren",  32'(iREN), 32'd0);
      chk("hold_addr",  imemaddr, 32'hC);
      chk("hold_instr", instr_out, 32'h2001_0005);
      chk("hold_npc",   npc_out, 32'h8);
      stall = 1'b0; ihit = 1'b0;
      tick();
      chk("rel_instr", instr_out, 32'hAC22_0000);
      chk("rel_npc",   npc_out, 32'hC);
      chk("rel_valid", 32'(valid_out), 32'd1);
      chk("rel_iren",  32'(iREN), 32'd1);

      // enter HOLD again, then redirect+flush under stall
      stall = 1'b1; ihit = 1'b1; imemload = 32'h1111_1111;
      tick();
      redirect = 1'b1; flush = 1'b1; redirect_pc = 32'h0000_0043;
      tick();
      chk("redir_addr",  imemaddr, 32'h40);
      chk("redir_valid", 32'(valid_out), 32'd0);
      chk("redir_instr", instr_out, 32'h0);
      chk("redir_iren",  32'(iREN), 32'd1);
      redirect = 1'b0; flush = 1'b0; stall = 1'b0;
      ihit = 1'b1; imemload = 32'h8C01_0004;
      tick();
      chk("tgt_instr", instr_out, 32'h8C01_0004);
      chk("tgt_npc",   npc_out, 32'h44);
      chk("tgt_valid", 32'(valid_out), 32'd1);

      // three miss cycles
      ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("miss%0d_valid", i), 32'(valid_out), 32'd0);
         chk($sformatf("miss%0d_instr", i), instr_out, 32'h0);
         chk($sformatf("miss%0d_addr", i),  imemaddr, 32'h44);
      end

      // halt with a same-cycle hit
      halt = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
      tick();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_iren",   32'(iREN), 32'd0);
      chk("halt_valid",  32'(valid_out), 32'd0);
      chk("halt_instr",  instr_out, 32'h0);
      chk("halt_addr",   imemaddr, 32'h44);
      halt = 1'b0;
      tick();
      tick();
      chk("frozen_halted", 32'(halted), 32'd1);
      chk("frozen_addr",   imemaddr, 32'h44);
      chk("frozen_valid",  32'(valid_out), 32'd0);

      RST = 1'b1;
      #1;
      chk("rst2_halted", 32'(halted), 32'd0);
      chk("rst2_addr",   imemaddr, 32'h0);
      chk("rst2_iren",   32'(iREN), 32'd0);
      RST = 1'b0;
      #1;
      chk("rst2_run_iren", 32'(iREN), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage with integrated IF/ID latch for the pipelined MIPS datapath. Owns the PC, issues word reads to instruction memory over the iREN/ihit handshake, and presents a registered instruction plus PC+4 to the downstream control/decode stage. Handles stalls without losing a returned word, branch/jump redirects, IF/ID flushes, and HALT freeze.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction memory returns imemload this cycle
- imemload  in  32  instruction word from memory
- iREN  out  1  instruction read request
- imemaddr  out  32  fetch address, {pc[31:2],2'b00}
- stall  in  1  decode cannot accept; hold IF/ID
- flush  in  1  squash IF/ID contents (taken branch/jump)
- redirect  in  1  load redirect_pc into PC
- redirect_pc  in  32  target address; bits [1:0] ignored
- halt  in  1  decode saw valid HALT; freeze fetch
- instr_out  out  32  IF/ID instruction (to control instruction input)
- npc_out  out  32  IF/ID PC+4
- valid_out  out  1  IF/ID holds a real instruction
- halted  out  1  fetch frozen by HALT

## Operation
- States: FETCH, HOLD, HALTED.
- Reset (async): pc=PC_INIT, state=FETCH, instr_out=0, npc_out=0, valid_out=0, halted=0, buffer cleared; iREN=0 while RST high.
- FETCH: iREN=1.
  - ihit & !stall: IF/ID <= {imemload, pc+4}, valid_out<=1, pc<=pc+4.
  - ihit & stall: buffer <= {imemload, pc+4}, pc<=pc+4, IF/ID held, -> HOLD.
  - !ihit & !stall: valid_out<=0 (bubble), instr_out<=0.
  - !ihit & stall: IF/ID held.
- HOLD: iREN=0. stall high: hold. stall low: IF/ID <= buffer, valid_out<=1, -> FETCH.
- HALTED: iREN=0, halted=1, valid_out=0, instr_out=0; exits only on RST.
- Priority per cycle: RST > halt > redirect/flush > stall > ihit.
- halt: -> HALTED next edge; any ihit that cycle discarded.
- redirect: pc<=redirect_pc & ~3, state->FETCH, buffer discarded, same-cycle ihit discarded; applies even when stall high.
- flush: valid_out<=0, instr_out<=0, npc_out<=0; overrides stall. flush without redirect leaves pc and state untouched except HOLD buffer discarded (-> FETCH, pc unchanged; dropped word refetched is not required—caller always pairs flush with redirect or accepts the loss).
- pc arithmetic: 32-bit modulo; 0xFFFF_FFFC+4 = 0.

## Timing
- Latency: ihit at cycle N -> instr_out/valid_out valid after edge ending N (visible cycle N+1).
- Throughput: one instruction per cycle when ihit held high and stall low.
- iREN and imemaddr combinational from state and pc; no dependence on ihit same cycle.
- HOLD release: buffered word appears one cycle after stall drops; next fetch request issued in that same cycle.
- Redirect target requested on imemaddr the cycle after redirect.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count (32, valid instructions loaded into IF/ID) and stall_count (32, cycles with stall high outside HALTED); both reset to 0, saturate at 0xFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- cpu_types_pkg: word_t, fetch_state_t enum {FETCH, HOLD, HALTED}, PC_STEP=4.
- Sub-module ifid_latch: instr/npc/valid register with load, hold, clear; instantiated for IF/ID and for the HOLD buffer.

## Test plan
- Reset with PC_INIT=0, ihit=1 each cycle, imemload=0x2001_0005 -> imemaddr 0,4,8; instr_out=0x2001_0005, npc_out=4 one cycle after first ihit; valid_out=1.
- stall high at ihit with pc=8, imemload=0xAC22_0000 -> state HOLD, iREN=0, pc=0xC; release stall -> instr_out=0xAC22_0000, npc_out=0xC next cycle.
- redirect=1, flush=1, redirect_pc=0x0000_0043 while stall high -> next imemaddr=0x40, valid_out=0, instr_out=0.
- ihit low 3 cycles -> valid_out=0, instr_out=0 each cycle, imemaddr constant.
- halt=1 with ihit=1 -> halted=1, iREN=0 next cycle, pc frozen; only RST clears.
- PC_INIT=0xFFFF_FFFC, ihit=1 -> npc_out=0, next imemaddr=0.
